regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback sources.
- Source 1 is the in-order pipeline WB stage: highest priority, no backpressure.
- Source 2 is a long-latency unit (mul/div, late load) using a valid/ready handshake, buffered in a small FIFO.
- A starvation counter forces a write slot for the FIFO by stalling the pipeline. A pending-destination mask lets decode detect WAW/RAW against buffered results.

Parameters:
- DATA_WIDTH, 32, width of write data.
- FIFO_DEPTH, 2, entries in the long-op buffer; power of 2, at least 2.
- MAX_WAIT, 4, cycles a non-empty FIFO may go without a grant before a stall is forced; at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- pipe_wb_valid  in  1  pipeline WB write request this cycle.
- pipe_wb_reg  in  5  pipeline destination register.
- pipe_wb_data  in  DATA_WIDTH  pipeline write data.
- lop_valid  in  1  long-op result valid.
- lop_ready  out  1  arbiter can accept a long-op result.
- lop_reg  in  5  long-op destination register.
- lop_data  in  DATA_WIDTH  long-op result.
- rf_write_enable  out  1  to register file write_enable.
- rf_write_reg  out  5  to register file write_reg.
- rf_write_data  out  DATA_WIDTH  to register file write_data.
- stall_pipe  out  1  registered; pipeline must hold WB valid low while high.
- lop_pending_mask  out  32  bit r set if any FIFO entry targets register r.
- protocol_err  out  1  sticky; pipe_wb_valid seen high while stall_pipe high.

Behaviour:
- Reset (asynchronous, active-high), while asserted and after release:
  - FIFO empty, wait counter 0.
  - stall_pipe=0, protocol_err=0, lop_ready=1.
  - rf_write_enable=0 (forced low combinationally during reset), lop_pending_mask=0.
- Reset mid-operation discards buffered results. The issuing logic must reset as well.
- Write port path is combinational, zero added latency: the register file commits on the same edge the request is presented.
- Grant priority, each cycle:
  - If stall_pipe=0 and pipe_wb_valid=1 and pipe_wb_reg!=0: grant the pipe. The port carries the pipe reg/data.
  - Else if the FIFO is non-empty: grant the FIFO head. rf_write_enable=1 with head reg/data; the head pops on the edge.
  - Else rf_write_enable=0.
- Pipe writes to x0 never take the port. The FIFO head may use that cycle.
- stall_pipe=1 makes the FIFO head win regardless of pipe_wb_valid. A pipe request seen that cycle is dropped and sets protocol_err, which stays set until reset.
- Long-op handshake:
  - Transfer occurs when lop_valid and lop_ready are both high at the edge.
  - lop_ready = !full, OR full and a pop happens this cycle (same-cycle push+pop allowed when full).
  - lop_reg=0 transfers are accepted and discarded; they are never enqueued and never touch the mask.
  - lop_reg/lop_data must be held stable while lop_valid=1 and lop_ready=0.
- FIFO:
  - Circular, log2(FIFO_DEPTH)+1-bit read/write pointers with wrap.
  - Full/empty derived from pointer MSB compare.
  - Push and pop in the same cycle keep occupancy unchanged, including when empty: no bypass, the push lands and pops on a later cycle.
- Wait counter:
  - Resets to 0 on any FIFO pop, or when the FIFO is empty.
  - Otherwise increments while the FIFO is non-empty and not granted, saturating at MAX_WAIT.
- stall_pipe:
  - Set on the edge where the counter value equals MAX_WAIT-1 and is incrementing.
  - Cleared on the edge where a FIFO pop occurs.
  - Therefore high for exactly one cycle per forced slot.
- lop_pending_mask:
  - OR over valid entries of a one-hot decode of each entry's reg.
  - Updates the cycle after push/pop.
  - Decode stalls any instruction whose rs1/rs2/rd hits the mask. The arbiter does not check ordering.

Test Plan:
- Reset with lop_valid=1 held -> all outputs at reset values. After release, lop_ready=1 and the first long-op is enqueued on the next edge.
- Idle pipe; long-op reg=7 data=0xDEADBEEF -> next cycle rf_write_enable=1, reg=7, data=0xDEADBEEF; mask bit7 set for one cycle, then clear.
- pipe_wb_valid continuous (reg=3) with FIFO holding reg=9 -> pipe granted for MAX_WAIT=4 cycles, then stall_pipe=1 for one cycle, during which reg=9 is written; counter returns to 0.
- Push 2 long-ops (regs 1 and 2) while the pipe writes every cycle -> lop_ready=0 when full; a third push is accepted only in the pop cycle; write order 1, 2, 3.
- lop_reg=0 and pipe_wb_reg=0 stimulus -> no rf_write_enable, mask stays 0, FIFO stays empty.
- pipe_wb_valid=1 during stall_pipe=1 -> FIFO head written, protocol_err=1 and remains 1 until reset.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Shares the register-file write port between the pipeline WB
//             stage and a FIFO-buffered long-latency result stream.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_wb_valid,
    input  logic [4:0]            pipe_wb_reg,
    input  logic [DATA_WIDTH-1:0] pipe_wb_data,
    input  logic                  lop_valid,
    output logic                  lop_ready,
    input  logic [4:0]            lop_reg,
    input  logic [DATA_WIDTH-1:0] lop_data,
    output logic                  rf_write_enable,
    output logic [4:0]            rf_write_reg,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  stall_pipe,
    output logic [31:0]           lop_pending_mask,
    output logic                  protocol_err
);

    localparam int c_IDX_W = $clog2(FIFO_DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;
    localparam int c_CNT_W = $clog2(MAX_WAIT + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_WAIT_MAX  = c_CNT_W'(MAX_WAIT);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(MAX_WAIT - 1);

    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [FIFO_DEPTH-1:0] r_entry_valid;
    logic [4:0]            r_fifo_reg  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [c_CNT_W-1:0]    r_wait_cnt;
    logic                  r_stall_pipe;
    logic                  r_protocol_err;

    logic [c_IDX_W-1:0]    w_wr_idx;
    logic [c_IDX_W-1:0]    w_rd_idx;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pipe_grant;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_cnt_inc;
    logic [31:0]           w_mask;

    assign w_wr_idx = r_wr_ptr[c_IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[c_IDX_W-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_wr_idx == w_rd_idx) &&
                      (r_wr_ptr[c_PTR_W-1] != r_rd_ptr[c_PTR_W-1]);

    // x0 writes never occupy the port, leaving the slot to the FIFO head.
    assign w_pipe_grant = !r_stall_pipe && pipe_wb_valid && (pipe_wb_reg != 5'd0);
    assign w_pop        = !w_pipe_grant && !w_empty;

    assign lop_ready = !w_full || w_pop;
    assign w_push    = lop_valid && lop_ready && (lop_reg != 5'd0);

    assign w_cnt_inc = !w_empty && !w_pop && (r_wait_cnt != c_WAIT_MAX);

    always_comb begin
        rf_write_enable = 1'b0;
        rf_write_reg    = r_fifo_reg[w_rd_idx];
        rf_write_data   = r_fifo_data[w_rd_idx];
        if (w_pipe_grant) begin
            rf_write_reg  = pipe_wb_reg;
            rf_write_data = pipe_wb_data;
        end
        if (!reset) begin
            rf_write_enable = w_pipe_grant || w_pop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_entry_valid <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr                <= r_rd_ptr + c_PTR_ONE;
                r_entry_valid[w_rd_idx] <= 1'b0;
            end
            // When full, push and pop share one slot; the push must win.
            if (w_push) begin
                r_wr_ptr                <= r_wr_ptr + c_PTR_ONE;
                r_entry_valid[w_wr_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_reg[w_wr_idx]  <= lop_reg;
            r_fifo_data[w_wr_idx] <= lop_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt     <= '0;
            r_stall_pipe   <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_pop || w_empty) begin
                r_wait_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
            end

            if (w_pop) begin
                r_stall_pipe <= 1'b0;
            end else if (w_cnt_inc && (r_wait_cnt == c_WAIT_LAST)) begin
                r_stall_pipe <= 1'b1;
            end

            if (r_stall_pipe && pipe_wb_valid) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_entry_valid[i]) begin
                w_mask[r_fifo_reg[i]] = 1'b1;
            end
        end
    end

    assign stall_pipe       = r_stall_pipe;
    assign protocol_err     = r_protocol_err;
    assign lop_pending_mask = w_mask;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Directed self-checking bench for regfile_wb_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_reg;
    logic [31:0] pipe_wb_data;
    logic        lop_valid;
    logic        lop_ready;
    logic [4:0]  lop_reg;
    logic [31:0] lop_data;
    logic        rf_write_enable;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic        stall_pipe;
    logic [31:0] lop_pending_mask;
    logic        protocol_err;

    int n_vec = 0;
    int n_err = 0;

    regfile_wb_arbiter #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (2),
        .MAX_WAIT   (4)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .pipe_wb_valid    (pipe_wb_valid),
        .pipe_wb_reg      (pipe_wb_reg),
        .pipe_wb_data     (pipe_wb_data),
        .lop_valid        (lop_valid),
        .lop_ready        (lop_ready),
        .lop_reg          (lop_reg),
        .lop_data         (lop_data),
        .rf_write_enable  (rf_write_enable),
        .rf_write_reg     (rf_write_reg),
        .rf_write_data    (rf_write_data),
        .stall_pipe       (stall_pipe),
        .lop_pending_mask (lop_pending_mask),
        .protocol_err     (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pipe owns the port for MAX_WAIT cycles, then one forced slot for the FIFO head.
    task automatic starve_then_pop(input logic [4:0] preg, input logic [4:0] hreg,
                                   input logic [31:0] hdata);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("starve_pipe_reg", 64'(rf_write_reg), 64'(preg));
            check("starve_no_stall", 64'(stall_pipe), 64'd0);
            step();
        end
        #1;
        check("forced_stall", 64'(stall_pipe), 64'd1);
        check("forced_we", 64'(rf_write_enable), 64'd1);
        check("forced_reg", 64'(rf_write_reg), 64'(hreg));
        check("forced_data", 64'(rf_write_data), 64'(hdata));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a long-op and a pipe request both held high.
        reset         = 1'b1;
        pipe_wb_valid = 1'b1;
        pipe_wb_reg   = 5'd4;
        pipe_wb_data  = 32'h4444_4444;
        lop_valid     = 1'b1;
        lop_reg       = 5'd7;
        lop_data      = 32'hDEAD_BEEF;
        #1;
        check("rst_we", 64'(rf_write_enable), 64'd0);
        check("rst_stall", 64'(stall_pipe), 64'd0);
        check("rst_perr", 64'(protocol_err), 64'd0);
        check("rst_ready", 64'(lop_ready), 64'd1);
        check("rst_mask", 64'(lop_pending_mask), 64'd0);
        step();
        step();
        check("rst_mask_held", 64'(lop_pending_mask), 64'd0);

        pipe_wb_valid = 1'b0;
        reset         = 1'b0;
        #1;
        check("post_rst_ready", 64'(lop_ready), 64'd1);
        check("post_rst_we", 64'(rf_write_enable), 64'd0);
        step();
        lop_valid = 1'b0;
        #1;
        check("lop7_we", 64'(rf_write_enable), 64'd1);
        check("lop7_reg", 64'(rf_write_reg), 64'd7);
        check("lop7_data", 64'(rf_write_data), 64'hDEAD_BEEF);
        check("lop7_mask", 64'(lop_pending_mask), 64'h0000_0080);
        step();
        check("lop7_mask_clr", 64'(lop_pending_mask), 64'd0);
        check("lop7_idle_we", 64'(rf_write_enable), 64'd0);

        // Starvation: continuous pipe writes to x3, one buffered write to x9.
        pipe_wb_valid = 1'b1;
        pipe_wb_reg   = 5'd3;
        pipe_wb_data  = 32'h3333_3333;
        lop_valid     = 1'b1;
        lop_reg       = 5'd9;
        lop_data      = 32'h9999_9999;
        #1;
        check("pipe3_reg", 64'(rf_write_reg), 64'd3);
        check("pipe3_data", 64'(rf_write_data), 64'h3333_3333);
        step();
        lop_valid = 1'b0;
        check("lop9_mask", 64'(lop_pending_mask), 64'h0000_0200);
        starve_then_pop(5'd3, 5'd9, 32'h9999_9999);
        check("perr_set", 64'(protocol_err), 64'd1);
        check("stall_clr", 64'(stall_pipe), 64'd0);
        check("pipe3_back", 64'(rf_write_reg), 64'd3);
        check("lop9_mask_clr", 64'(lop_pending_mask), 64'd0);

        // Fill the FIFO while the pipe writes x4 every cycle.
        pipe_wb_reg  = 5'd4;
        pipe_wb_data = 32'h4444_4444;
        lop_valid    = 1'b1;
        lop_reg      = 5'd1;
        lop_data     = 32'h1111_1111;
        #1;
        check("fill1_ready", 64'(lop_ready), 64'd1);
        step();
        lop_reg  = 5'd2;
        lop_data = 32'h2222_2222;
        #1;
        check("fill2_ready", 64'(lop_ready), 64'd1);
        check("fill2_pipe", 64'(rf_write_reg), 64'd4);
        step();
        lop_reg  = 5'd3;
        lop_data = 32'h3333_0003;
        #1;
        check("full_ready", 64'(lop_ready), 64'd0);
        check("full_mask", 64'(lop_pending_mask), 64'h0000_0006);
        step();
        check("full_ready_b3", 64'(lop_ready), 64'd0);
        step();
        check("full_ready_b4", 64'(lop_ready), 64'd0);
        check("full_stall_b4", 64'(stall_pipe), 64'd0);
        step();
        check("pop1_stall", 64'(stall_pipe), 64'd1);
        check("pop1_ready", 64'(lop_ready), 64'd1);
        check("pop1_reg", 64'(rf_write_reg), 64'd1);
        check("pop1_data", 64'(rf_write_data), 64'h1111_1111);
        step();
        lop_valid = 1'b0;
        #1;
        check("refill_ready", 64'(lop_ready), 64'd0);
        check("refill_mask", 64'(lop_pending_mask), 64'h0000_000C);
        starve_then_pop(5'd4, 5'd2, 32'h2222_2222);
        starve_then_pop(5'd4, 5'd3, 32'h3333_0003);
        check("drain_mask", 64'(lop_pending_mask), 64'd0);
        check("drain_pipe", 64'(rf_write_reg), 64'd4);

        // x0 targets on both sources.
        pipe_wb_reg  = 5'd0;
        pipe_wb_data = 32'hAAAA_AAAA;
        lop_valid    = 1'b1;
        lop_reg      = 5'd0;
        lop_data     = 32'hBBBB_BBBB;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("x0_we", 64'(rf_write_enable), 64'd0);
            check("x0_ready", 64'(lop_ready), 64'd1);
            check("x0_mask", 64'(lop_pending_mask), 64'd0);
            step();
        end
        lop_reg  = 5'd12;
        lop_data = 32'h0000_000C;
        step();
        lop_valid = 1'b0;
        #1;
        check("x0_slot_we", 64'(rf_write_enable), 64'd1);
        check("x0_slot_reg", 64'(rf_write_reg), 64'd12);
        check("x0_slot_data", 64'(rf_write_data), 64'h0000_000C);
        step();
        check("x0_slot_done", 64'(rf_write_enable), 64'd0);
        check("x0_slot_mask", 64'(lop_pending_mask), 64'd0);
        pipe_wb_valid = 1'b0;

        // Sticky error, then reset mid-operation with a result buffered.
        check("perr_sticky", 64'(protocol_err), 64'd1);
        lop_valid = 1'b1;
        lop_reg   = 5'd20;
        lop_data  = 32'h2020_2020;
        step();
        lop_valid = 1'b0;
        #1;
        check("lop20_mask", 64'(lop_pending_mask), 64'h0010_0000);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_mask", 64'(lop_pending_mask), 64'd0);
        check("midrst_perr", 64'(protocol_err), 64'd0);
        check("midrst_we", 64'(rf_write_enable), 64'd0);
        check("midrst_ready", 64'(lop_ready), 64'd1);
        step();
        reset = 1'b0;
        #1;
        check("after_rst_we", 64'(rf_write_enable), 64'd0);
        pipe_wb_valid = 1'b1;
        pipe_wb_reg   = 5'd5;
        pipe_wb_data  = 32'h0505_0505;
        #1;
        check("after_rst_pipe_we", 64'(rf_write_enable), 64'd1);
        check("after_rst_pipe_reg", 64'(rf_write_reg), 64'd5);
        check("after_rst_pipe_data", 64'(rf_write_data), 64'h0505_0505);
        step();
        pipe_wb_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
